l2_request_arbiter: RTL
=======================

L2_REQUEST_ARBITER -- requirements
Module: l2_request_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2: number of L1 requesters sharing one L2; legal range 2..4.
REQ-002 Parameter TIMEOUT_CYCLES, default 64: watchdog limit in cycles; used only when L2_ARB_TIMEOUT_EN is defined.
REQ-003 Port clk  input  1: clock; all state changes on the rising edge.
REQ-004 Port reset  input  1: reset, asynchronous, active-high.
REQ-005 Ports req_read, req_write, req_wb  input  NUM_REQ each: per-requester read, write-through and write-back requests to L2.
REQ-006 Port req_addr  input  NUM_REQ x ADDRESS_WIDTH: per-requester L2 address.
REQ-007 Port req_wdata  input  NUM_REQ x DATA_WIDTH: per-requester write-through word.
REQ-008 Port req_wb_data  input  NUM_REQ x MAIN_MEMORY_DATA_WIDTH: per-requester write-back block.
REQ-009 Ports l2_read_request, l2_write_request, l2_write_back_request  output  1 each: requests forwarded to L2.
REQ-010 Ports l2_address  output  ADDRESS_WIDTH; l2_wdata  output  DATA_WIDTH; l2_wb_data  output  MAIN_MEMORY_DATA_WIDTH: latched payload of the granted requester.
REQ-011 Ports l2_ready, l2_write_verified, l2_write_back_verified  input  1 each: L2 completion strobes for read, write and write-back.
REQ-012 Ports gnt_ready, gnt_write_verified, gnt_wb_verified  output  NUM_REQ each: completion strobes routed to the granted requester only.
REQ-013 Port grant_id  output  $clog2(NUM_REQ): index of the current owner; valid while busy is 1.
REQ-014 Port busy  output  1: L2 is owned by a requester.
REQ-015 Port timeout_err  output  1: one-cycle pulse on watchdog abort; tied to 0 when the feature is compiled out.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, LATCH, WAIT, RELEASE.
REQ-017 IDLE: if any requester has any request bit set, select a winner by round-robin starting after last_grant, then go to LATCH; otherwise stay in IDLE.
REQ-018 LATCH: register the winner's address, data, block and operation, set grant_id and busy, assert exactly one l2_*_request from the next cycle, then go to WAIT.
REQ-019 Operation priority within one requester SHALL be write-back > write > read; the lower-priority request stays pending for a later grant.
REQ-020 WAIT: hold the l2_*_request and payload stable; on the matching L2 strobe, drive the matching gnt_* bit of grant_id combinationally in the same cycle, drop the l2 request from the next cycle, update last_grant to grant_id, then go to RELEASE.
REQ-021 A non-matching L2 strobe during WAIT SHALL be ignored and SHALL NOT be routed.
REQ-022 If the granted requester deasserts its latched request during WAIT, drop the L2 request, route nothing, and go to RELEASE; if the matching strobe arrives in the same cycle, the completion SHALL be delivered.
REQ-023 RELEASE: one dead cycle with busy=0 and no L2 request so the requester can drop its request; then go to IDLE.
REQ-024 Latency: request sampled in IDLE at cycle n -> l2 request high at n+2; minimum per-transaction occupancy is 4 cycles.
REQ-025 A requester with continuous requests SHALL never be granted twice in a row while another requester is pending.
REQ-026 gnt_* bits SHALL be one-hot or zero; never more than one l2_*_request SHALL be high.

Reset
REQ-027 On reset: state=IDLE, last_grant=NUM_REQ-1 (requester 0 wins first), all outputs 0, latched payload 0.
REQ-028 Reset asserted mid-transaction SHALL abandon it immediately with no completion routed.

Configuration
REQ-029 With L2_ARB_TIMEOUT_EN defined: a counter clears on entry to WAIT and increments every WAIT cycle; at TIMEOUT_CYCLES it drops the L2 request, pulses timeout_err, advances last_grant and goes to RELEASE.
REQ-030 Without L2_ARB_TIMEOUT_EN: no counter is built, WAIT is held indefinitely, and timeout_err is constant 0.

Structure
REQ-031 The arbiter state enum and NUM_REQ default SHALL live in the shared cache_config package beside the cache FSM types; address and data widths come from cache_config and main_memory_config.
REQ-032 One sub-module, rr_pick, SHALL implement the combinational round-robin winner selection (request vector and last_grant in; winner and valid out).

Verification
REQ-033 After reset, req_read[0]=req_read[1]=1 in the same cycle, addr0=0x40000010 -> grant_id=0, l2_address=0x40000010 at n+2; after l2_ready -> gnt_ready=01, then requester 1 is granted.
REQ-034 Requester 0 has req_wb=1 and req_read=1 -> write-back is issued first with l2_wb_data=req_wb_data[0]; the read is issued on the next grant.
REQ-035 Both requesters continuously requesting for 8 transactions -> grant_id sequence 0,1,0,1,0,1,0,1.
REQ-036 In WAIT for a write, l2_ready pulses -> no gnt_* asserted and the FSM stays in WAIT until l2_write_verified -> gnt_write_verified=01.
REQ-037 Reset pulsed during WAIT -> all outputs 0 next edge and no gnt_* pulse; with L2_ARB_TIMEOUT_EN and no L2 response -> timeout_err pulses after exactly 64 WAIT cycles, then RELEASE.

Source files
------------

// File: rtl/cache_config.sv
// Shared cache configuration: widths, cache FSM types and L2 arbiter types.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
package cache_config;

  localparam int ADDRESS_WIDTH  = 32;
  localparam int DATA_WIDTH     = 32;

  // Number of L1 requesters sharing the L2 by default (legal 2..4).
  localparam int L2_ARB_NUM_REQ = 2;

  // L1 cache controller states.
  typedef enum logic [2:0] {
    CACHE_IDLE,
    CACHE_COMPARE_TAG,
    CACHE_ALLOCATE,
    CACHE_WRITE_BACK
  } cache_state_t;

  // L2 request arbiter states.
  typedef enum logic [1:0] {
    IDLE,
    LATCH,
    WAIT,
    RELEASE
  } l2_arb_state_t;

  // Operation latched for the current L2 owner.
  typedef enum logic [1:0] {
    OP_NONE,
    OP_READ,
    OP_WRITE,
    OP_WB
  } l2_op_t;

  // Pick one operation from a requester: write-back beats write beats read,
  // so a dirty eviction always reaches L2 before the refill that needs it.
  function automatic l2_op_t l2_op_sel(input logic rd, input logic wr, input logic wb);
    l2_op_t op;
    op = OP_NONE;
    if (wb) begin
      op = OP_WB;
    end else if (wr) begin
      op = OP_WRITE;
    end else if (rd) begin
      op = OP_READ;
    end
    return op;
  endfunction

endpackage : cache_config

// File: rtl/main_memory_config.sv
// Shared main-memory geometry used by the cache hierarchy.
// Latency: n/a (constants only).
// Backpressure: n/a.
package main_memory_config;

  // Width of one write-back block moved between L2 and main memory.
  localparam int MAIN_MEMORY_DATA_WIDTH = 128;

endpackage : main_memory_config

// File: rtl/l2_request_arbiter_rr_pick.sv
// Round-robin winner selection over a request vector, starting after last_grant.
// Latency: purely combinational.
// Backpressure: none; valid_o low when no requester is pending.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     last_grant_i,
  output logic [IDW-1:0]     winner_o,
  output logic               valid_o
);

  // Scan from last_grant+1 around the ring; the first pending requester wins.
  always_comb begin
    int   idx;
    logic found;
    idx      = 0;
    found    = 1'b0;
    winner_o = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last_grant_i) + i) % NUM_REQ;
      if (!found && req_i[IDW'(idx)]) begin
        found    = 1'b1;
        winner_o = IDW'(idx);
      end
    end
    valid_o = found;
  end

endmodule : rr_pick

// File: rtl/l2_request_arbiter.sv
// Arbitrates NUM_REQ L1 requesters onto one L2 port (IDLE/LATCH/WAIT/RELEASE).
// Latency: request seen in IDLE at n -> l2_*_request at n+2; >= 4 cycles per transaction.
// Backpressure: the owner holds the L2 until its matching strobe, a request drop,
//   or (with L2_ARB_TIMEOUT_EN defined) a TIMEOUT_CYCLES watchdog abort.
module l2_request_arbiter
  import cache_config::*;
  import main_memory_config::*;
#(
  parameter int NUM_REQ        = L2_ARB_NUM_REQ,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [NUM_REQ-1:0]                        req_read,
  input  logic [NUM_REQ-1:0]                        req_write,
  input  logic [NUM_REQ-1:0]                        req_wb,
  input  logic [NUM_REQ-1:0][ADDRESS_WIDTH-1:0]     req_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]        req_wdata,
  input  logic [NUM_REQ-1:0][MAIN_MEMORY_DATA_WIDTH-1:0] req_wb_data,
  output logic                                      l2_read_request,
  output logic                                      l2_write_request,
  output logic                                      l2_write_back_request,
  output logic [ADDRESS_WIDTH-1:0]                  l2_address,
  output logic [DATA_WIDTH-1:0]                     l2_wdata,
  output logic [MAIN_MEMORY_DATA_WIDTH-1:0]         l2_wb_data,
  input  logic                                      l2_ready,
  input  logic                                      l2_write_verified,
  input  logic                                      l2_write_back_verified,
  output logic [NUM_REQ-1:0]                        gnt_ready,
  output logic [NUM_REQ-1:0]                        gnt_write_verified,
  output logic [NUM_REQ-1:0]                        gnt_wb_verified,
  output logic [$clog2(NUM_REQ)-1:0]                grant_id,
  output logic                                      busy,
  output logic                                      timeout_err
);

  localparam int IDW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("l2_request_arbiter: NUM_REQ must be 2..4 and TIMEOUT_CYCLES >= 2");
  end

  l2_arb_state_t                     state_q;
  l2_op_t                            op_q;
  l2_op_t                            win_op;
  logic [IDW-1:0]                    winner_q;
  logic [IDW-1:0]                    last_grant_q;
  logic [IDW-1:0]                    grant_id_q;
  logic                              busy_q;
  logic                              rd_req_q;
  logic                              wr_req_q;
  logic                              wb_req_q;
  logic [ADDRESS_WIDTH-1:0]          addr_q;
  logic [DATA_WIDTH-1:0]             wdata_q;
  logic [MAIN_MEMORY_DATA_WIDTH-1:0] wb_data_q;

  logic [NUM_REQ-1:0] any_req;
  logic [IDW-1:0]     pick_winner;
  logic               pick_vld;
  logic               still_req;
  logic               strobe_hit;
  logic               tmo_hit;
  logic [NUM_REQ-1:0] gnt_sel;

  assign any_req = req_read | req_write | req_wb;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_rr_pick (
    .req_i        (any_req),
    .last_grant_i (last_grant_q),
    .winner_o     (pick_winner),
    .valid_o      (pick_vld)
  );

  // Decode the winner's operation and, for the current owner, whether it still
  // requests and whether this cycle carries its matching L2 strobe.
  always_comb begin
    win_op     = l2_op_sel(req_read[winner_q], req_write[winner_q], req_wb[winner_q]);
    still_req  = 1'b0;
    strobe_hit = 1'b0;
    case (op_q)
      OP_READ: begin
        still_req  = req_read[grant_id_q];
        strobe_hit = l2_ready;
      end
      OP_WRITE: begin
        still_req  = req_write[grant_id_q];
        strobe_hit = l2_write_verified;
      end
      OP_WB: begin
        still_req  = req_wb[grant_id_q];
        strobe_hit = l2_write_back_verified;
      end
      default: begin
        still_req  = 1'b0;
        strobe_hit = 1'b0;
      end
    endcase
  end

  // Completions go combinationally to the owner only, and only in WAIT; a strobe
  // for a different operation type is simply not routed.
  always_comb begin
    gnt_sel            = (state_q == WAIT) ? (NUM_REQ'(1) << grant_id_q) : '0;
    gnt_ready          = (op_q == OP_READ  && l2_ready)               ? gnt_sel : '0;
    gnt_write_verified = (op_q == OP_WRITE && l2_write_verified)      ? gnt_sel : '0;
    gnt_wb_verified    = (op_q == OP_WB    && l2_write_back_verified) ? gnt_sel : '0;
  end

`ifdef L2_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wait_cnt_q;
  logic          timeout_err_q;

  assign tmo_hit     = (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_err_q;

  // Watchdog: count WAIT cycles from zero; abort pulse when the limit is reached
  // without the matching strobe (a real completion on that cycle wins).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= (state_q == WAIT) && tmo_hit && !strobe_hit && still_req;
      if (state_q == WAIT) begin
        wait_cnt_q <= wait_cnt_q + TW'(1);
      end else begin
        wait_cnt_q <= '0;
      end
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Arbiter FSM with registered L2 request, payload, grant_id and busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      op_q         <= OP_NONE;
      winner_q     <= '0;
      last_grant_q <= IDW'(NUM_REQ - 1);
      grant_id_q   <= '0;
      busy_q       <= 1'b0;
      rd_req_q     <= 1'b0;
      wr_req_q     <= 1'b0;
      wb_req_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wb_data_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            winner_q <= pick_winner;
            state_q  <= LATCH;
          end
        end
        LATCH: begin
          if (win_op != OP_NONE) begin
            grant_id_q <= winner_q;
            busy_q     <= 1'b1;
            op_q       <= win_op;
            rd_req_q   <= (win_op == OP_READ);
            wr_req_q   <= (win_op == OP_WRITE);
            wb_req_q   <= (win_op == OP_WB);
            addr_q     <= req_addr[winner_q];
            wdata_q    <= req_wdata[winner_q];
            wb_data_q  <= req_wb_data[winner_q];
            state_q    <= WAIT;
          end else begin
            // Winner withdrew between pick and latch: nothing to issue.
            state_q <= RELEASE;
          end
        end
        WAIT: begin
          // Completion, withdrawal or watchdog all end ownership; the owner
          // has had its turn in each case, so last_grant advances to it.
          if (strobe_hit || !still_req || tmo_hit) begin
            busy_q       <= 1'b0;
            op_q         <= OP_NONE;
            rd_req_q     <= 1'b0;
            wr_req_q     <= 1'b0;
            wb_req_q     <= 1'b0;
            last_grant_q <= grant_id_q;
            state_q      <= RELEASE;
          end
        end
        RELEASE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign l2_read_request       = rd_req_q;
  assign l2_write_request      = wr_req_q;
  assign l2_write_back_request = wb_req_q;
  assign l2_address            = addr_q;
  assign l2_wdata              = wdata_q;
  assign l2_wb_data            = wb_data_q;
  assign grant_id              = grant_id_q;
  assign busy                  = busy_q;

endmodule : l2_request_arbiter
